multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore control FSM that sequences the multi-cycle datapath: PC, IR, register file, ALU and its result register, and memory.
- Decodes the 6-bit opcode and steps each instruction through FETCH/DECODE/EXEC/MEM/WB, waiting on a memory-ready handshake.
- Counts retired instructions.
- Halts on an illegal opcode or a memory timeout.

Parameters:
- CNT_W, 32, retired-instruction counter width.
- MEM_TIMEOUT, 16, maximum cycles spent waiting for mem_ready in any memory state; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  run enable.
- opcode  input  6  IR[31:26].
- mem_ready  input  1  memory access complete this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- iord  output  1  memory address select (0=PC, 1=ALU result register).
- mem_read  output  1  memory read.
- mem_write  output  1  memory write.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  writeback data select.
- reg_dst  output  1  destination select (1=rd).
- reg_write  output  1  register file write.
- alu_src_a  output  1  ALU A select (0=PC, 1=A register).
- alu_src_b  output  2  ALU B select (00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2).
- alu_op  output  2  ALU op (00=add, 01=sub, 10=funct).
- pc_source  output  2  PC source (00=ALU, 01=ALU result register, 10=jump target).
- instr_done  output  1  one-cycle retire pulse.
- retired  output  CNT_W  retired-instruction count.
- halted  output  1  FSM in HALT.
- halt_cause  output  2  00=none, 01=illegal opcode, 10=memory timeout.

Behaviour:
- State register, retired, halt_cause and the watchdog counter clear asynchronously when rst=0. The FSM resets to IDLE.
- All control outputs are decoded combinationally from the state (plus mem_ready where noted). Every output is 0 in IDLE and after reset.
- IDLE: all outputs 0. Go to FETCH when en=1.
- FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, iord=0.
  - ir_write and pc_write equal mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - 000000 -> EXEC.
  - 100011 or 101011 -> MEMADR.
  - 000100 -> BRANCH.
  - 000010 -> JUMP.
  - 001000 -> ADDIEX.
  - Any other opcode -> HALT with cause 01.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw (opcode held stable by the IR).
- MEMRD: mem_read=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Final state.
- MEMWR: mem_write=1, iord=1. Wait for mem_ready; the cycle with mem_ready=1 is final.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Final state.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Final state.
- JUMP: pc_write=1, pc_source=10. Final state.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Final state.
- Final-state cycle:
  - instr_done=1 and retired increments; the new value is visible next cycle.
  - retired wraps from 2^CNT_W-1 to 0.
  - Next state is FETCH if en=1, else IDLE. en is not sampled elsewhere, so an instruction in flight always completes.
- Latencies in cycles, with zero memory wait:
  - R-type 4, addi 4, beq 3, j 3, lw 5, sw 4.
  - Each memory wait cycle adds one.
- Watchdog:
  - Counts consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready=1 or on leaving those states.
  - When the count reaches MEM_TIMEOUT while mem_ready is still 0, go to HALT with cause 10.
- HALT:
  - All control outputs 0, halted=1.
  - Absorbing: leaves only on reset.
  - en and mem_ready are ignored.
  - retired is frozen.
- Reset asserted mid-instruction: immediate return to IDLE; no partial instr_done.

Decomposition:
- Shared package holds:
  - state encoding (4-bit enum: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB, HALT);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOp, ALUSrcB and PCSource codes;
  - halt_cause codes.
- One sub-module, mem_watchdog: counter plus timeout compare, instantiated once. The FSM, output decode and retire counter stay in multicycle_ctrl.

Test Plan:
- Reset, then en=1, mem_ready=1, opcode=000000.
  - States: IDLE, FETCH, DECODE, EXEC, ALUWB, FETCH.
  - In ALUWB: reg_write=1, reg_dst=1, instr_done=1.
  - retired=1 afterwards.
- lw (100011) with mem_ready low for 3 cycles in MEMRD.
  - FETCH..MEMWB spans 8 cycles.
  - iord=1 and mem_read=1 held throughout MEMRD.
  - One instr_done pulse, in MEMWB.
- Illegal opcode 111111 in DECODE.
  - Next cycle: halted=1, halt_cause=01, all controls 0.
  - Toggling en or mem_ready for 10 cycles changes nothing.
  - Asserting rst=0 returns to IDLE with halt_cause=00.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH.
  - HALT entered after 4 wait cycles, halt_cause=10.
  - pc_write and ir_write never asserted.
- beq (000100) then j (000010), back-to-back with en=1.
  - BRANCH: pc_write_cond=1, pc_source=01, alu_op=01.
  - JUMP: pc_write=1, pc_source=10.
  - Each takes 3 cycles; retired reaches 2.
- en dropped during EXEC; rst pulsed during MEMWR; counter wrap.
  - en drop: the instruction completes (instr_done in ALUWB), then IDLE.
  - rst in MEMWR: immediate IDLE, mem_write=0, no instr_done.
  - Wrap: with CNT_W=4 and 16 retirements, retired wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multi-cycle datapath controller:
//   - ctrl_state_t : 4-bit FSM state encoding
//   - OP_*         : 6-bit opcode values taken from IR[31:26]
//   - ALUOP_*, ALUB_*, PCSRC_* : datapath select codes
//   - HC_*         : halt cause codes
//   - is_mem_wait_state() : states that wait on mem_ready
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12,
        HALT   = 4'd13
    } ctrl_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] HC_NONE    = 2'b00;
    localparam logic [1:0] HC_ILLEGAL = 2'b01;
    localparam logic [1:0] HC_TIMEOUT = 2'b10;

    // States in which the FSM stalls on the memory handshake.
    function automatic logic is_mem_wait_state(input ctrl_state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// -----------------------------------------------------------------------------
// mem_watchdog
// Counts consecutive stalled memory cycles and flags a timeout.
//   clk, rst   : clock, asynchronous active-low reset
//   active     : FSM is in a state that waits on mem_ready
//   mem_ready  : memory access completes this cycle
//   timeout    : this is stall cycle number MEM_TIMEOUT and memory is still
//                not ready (combinational); never set when MEM_TIMEOUT == 0
// -----------------------------------------------------------------------------
module mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;
    logic          waiting;

    assign waiting = active & ~mem_ready;

    // wait_cnt holds the number of stall cycles already completed, so the
    // current stall cycle is number wait_cnt+1. It saturates at LAST because
    // the FSM leaves the waiting state on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!waiting) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore control FSM for a multi-cycle MIPS-style datapath.
//   clk, rst        : clock, asynchronous active-low reset
//   en              : run enable, sampled in IDLE and in final states only
//   opcode          : IR[31:26]
//   mem_ready       : memory access completes this cycle
//   pc_write .. pc_source : datapath control strobes and selects
//   instr_done      : one-cycle pulse in the final cycle of an instruction
//   retired         : retired-instruction count (wraps)
//   halted          : FSM is in HALT
//   halt_cause      : 00 none, 01 illegal opcode, 10 memory timeout
//   state_dbg       : current FSM state
//
// Memory handshake: in FETCH, MEMRD and MEMWR the request strobes (mem_read
// or mem_write) are held for as long as the FSM stays in that state; the
// access is complete in the cycle where mem_ready=1 and the FSM moves on at
// the following edge. mem_ready is ignored in every other state.
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output ctrl_state_t      state_dbg
);

    ctrl_state_t state, next_state;
    logic [1:0]  cause_next;
    logic        retire;
    logic        timeout;

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .active    (is_mem_wait_state(state)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            halt_cause <= HC_NONE;
            retired    <= '0;
        end else begin
            state      <= next_state;
            halt_cause <= cause_next;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state    = state;
        cause_next    = halt_cause;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;

        case (state)
            IDLE: begin
                if (en) next_state = FETCH;
            end
            FETCH: begin
                // PC+4 is computed every fetch cycle but only committed,
                // together with the IR load, when the word arrives.
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = DECODE;
                end else if (timeout) begin
                    next_state = HALT;
                    cause_next = HC_TIMEOUT;
                end
            end
            DECODE: begin
                // Branch target precompute: PC + (imm << 2).
                alu_src_b = ALUB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     next_state = EXEC;
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default: begin
                        next_state = HALT;
                        cause_next = HC_ILLEGAL;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALUB_IMM;
                // Only lw and sw reach here, so anything but lw is a store.
                next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    next_state = MEMWB;
                end else if (timeout) begin
                    next_state = HALT;
                    cause_next = HC_TIMEOUT;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                end else if (timeout) begin
                    next_state = HALT;
                    cause_next = HC_TIMEOUT;
                end
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALUB_IMM;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Every final state shares the same exit: en is only looked at here
        // and in IDLE, so an instruction in flight always completes.
        if (retire) begin
            next_state = en ? FETCH : IDLE;
        end
    end

    assign instr_done = retire;
    assign halted     = (state == HALT);
    assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl (CNT_W=4, MEM_TIMEOUT=4). Inputs change
// 1 ns after the rising edge; outputs are compared 2 ns after the edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [5:0]       opcode = '0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic             instr_done, halted;
    logic [CNT_W-1:0] retired;
    logic [1:0]       halt_cause;
    ctrl_state_t      state_dbg;

    int vec_count = 0;
    int err_count = 0;

    // Control word: {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc}
    localparam logic [15:0] E_IDLE       = 16'h0000;
    localparam logic [15:0] E_FETCH_WAIT = {10'b0001000000, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] E_FETCH_RDY  = {10'b1001010000, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] E_DECODE     = {10'b0000000000, 2'b11, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMADR     = {10'b0000000001, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMRD      = {10'b0011000000, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMWB      = {10'b0000001010, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMWR      = {10'b0010100000, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] E_EXEC       = {10'b0000000001, 2'b00, 2'b10, 2'b00};
    localparam logic [15:0] E_ALUWB      = {10'b0000000110, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] E_BRANCH     = {10'b0100000001, 2'b00, 2'b01, 2'b01};
    localparam logic [15:0] E_JUMP       = {10'b1000000000, 2'b00, 2'b00, 2'b10};

    multicycle_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .retired       (retired),
        .halted        (halted),
        .halt_cause    (halt_cause),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    function automatic logic [15:0] act_cw();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source};
    endfunction

    // Leaves the bench 1 ns after a rising edge with reset released, DUT in IDLE.
    task automatic reset_dut();
        rst       = 1'b0;
        en        = 1'b0;
        mem_ready = 1'b0;
        opcode    = OP_RTYPE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #2;
        vec_count++;
        if (state_dbg !== IDLE || act_cw() !== E_IDLE || instr_done !== 1'b0 ||
            retired !== 4'd0 || halted !== 1'b0 || halt_cause !== HC_NONE) begin
            err_count++;
            $display("FAIL reset: state=%0d cw=%h done=%b ret=%0d halted=%b cause=%b, expected IDLE, 0000, 0, 0, 0, 00",
                     state_dbg, act_cw(), instr_done, retired, halted, halt_cause);
        end
    endtask

    task automatic test_rtype();
        ctrl_state_t es[6] = '{IDLE, FETCH, DECODE, EXEC, ALUWB, FETCH};
        logic [15:0] ec[6] = '{E_IDLE, E_FETCH_RDY, E_DECODE, E_EXEC, E_ALUWB, E_FETCH_RDY};
        logic        ed[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        reset_dut();
        en = 1'b1;
        mem_ready = 1'b1;
        opcode = OP_RTYPE;
        for (int c = 0; c < 6; c++) begin
            #1;
            vec_count++;
            if (state_dbg !== es[c] || act_cw() !== ec[c] || instr_done !== ed[c]) begin
                err_count++;
                $display("FAIL rtype cyc%0d: state=%0d cw=%h done=%b, expected state=%0d cw=%h done=%b",
                         c, state_dbg, act_cw(), instr_done, es[c], ec[c], ed[c]);
            end
            @(posedge clk);
            #1;
        end
        #1;
        vec_count++;
        if (retired !== 4'd1) begin
            err_count++;
            $display("FAIL rtype_retired: got %0d, expected 1", retired);
        end
    endtask

    task automatic test_lw_wait();
        ctrl_state_t es[10] = '{IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMRD, MEMWB, IDLE};
        logic [15:0] ec[10] = '{E_IDLE, E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD,
                                E_MEMRD, E_MEMRD, E_MEMWB, E_IDLE};
        logic        rdy[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int          dones = 0;
        reset_dut();
        opcode = OP_LW;
        for (int c = 0; c < 10; c++) begin
            en = (c < 8);
            mem_ready = rdy[c];
            #1;
            if (instr_done === 1'b1) dones++;
            vec_count++;
            if (state_dbg !== es[c] || act_cw() !== ec[c] || instr_done !== (c == 8)) begin
                err_count++;
                $display("FAIL lw cyc%0d: state=%0d cw=%h done=%b, expected state=%0d cw=%h done=%b",
                         c, state_dbg, act_cw(), instr_done, es[c], ec[c], (c == 8));
            end
            @(posedge clk);
            #1;
        end
        #1;
        vec_count++;
        if (dones != 1 || retired !== 4'd1) begin
            err_count++;
            $display("FAIL lw_retire: pulses=%0d retired=%0d, expected 1 and 1", dones, retired);
        end
    endtask

    task automatic test_illegal();
        ctrl_state_t es[3] = '{IDLE, FETCH, DECODE};
        reset_dut();
        en = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b111111;
        for (int c = 0; c < 3; c++) begin
            #1;
            vec_count++;
            if (state_dbg !== es[c]) begin
                err_count++;
                $display("FAIL illegal_seq cyc%0d: state=%0d, expected %0d", c, state_dbg, es[c]);
            end
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 11; c++) begin
            #1;
            vec_count++;
            if (state_dbg !== HALT || halted !== 1'b1 || halt_cause !== HC_ILLEGAL ||
                act_cw() !== E_IDLE || instr_done !== 1'b0 || retired !== 4'd0) begin
                err_count++;
                $display("FAIL illegal_halt cyc%0d: state=%0d halted=%b cause=%b cw=%h done=%b ret=%0d, expected HALT 1 01 0000 0 0",
                         c, state_dbg, halted, halt_cause, act_cw(), instr_done, retired);
            end
            en = c[0];
            mem_ready = c[1];
            @(posedge clk);
            #1;
        end
        // Asynchronous reset: no clock edge between assertion and check.
        #1;
        rst = 1'b0;
        #1;
        vec_count++;
        if (state_dbg !== IDLE || halted !== 1'b0 || halt_cause !== HC_NONE) begin
            err_count++;
            $display("FAIL illegal_reset: state=%0d halted=%b cause=%b, expected IDLE 0 00",
                     state_dbg, halted, halt_cause);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        en = 1'b1;
        mem_ready = 1'b0;
        opcode = OP_RTYPE;
        for (int c = 0; c < 5; c++) begin
            #1;
            vec_count++;
            if (state_dbg !== ((c == 0) ? IDLE : FETCH) ||
                act_cw() !== ((c == 0) ? E_IDLE : E_FETCH_WAIT)) begin
                err_count++;
                $display("FAIL timeout_wait cyc%0d: state=%0d cw=%h, expected state=%0d cw=%h",
                         c, state_dbg, act_cw(), (c == 0) ? IDLE : FETCH,
                         (c == 0) ? E_IDLE : E_FETCH_WAIT);
            end
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1;
            #1;
            vec_count++;
            if (state_dbg !== HALT || halt_cause !== HC_TIMEOUT || halted !== 1'b1 ||
                pc_write !== 1'b0 || ir_write !== 1'b0) begin
                err_count++;
                $display("FAIL timeout_halt cyc%0d: state=%0d cause=%b halted=%b pcw=%b irw=%b, expected HALT 10 1 0 0",
                         c, state_dbg, halt_cause, halted, pc_write, ir_write);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        ctrl_state_t es[8] = '{IDLE, FETCH, DECODE, BRANCH, FETCH, DECODE, JUMP, FETCH};
        logic [15:0] ec[8] = '{E_IDLE, E_FETCH_RDY, E_DECODE, E_BRANCH, E_FETCH_RDY,
                               E_DECODE, E_JUMP, E_FETCH_RDY};
        reset_dut();
        en = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            opcode = (c < 4) ? OP_BEQ : OP_J;
            #1;
            vec_count++;
            if (state_dbg !== es[c] || act_cw() !== ec[c] ||
                instr_done !== (c == 3 || c == 6)) begin
                err_count++;
                $display("FAIL b2b cyc%0d: state=%0d cw=%h done=%b, expected state=%0d cw=%h done=%b",
                         c, state_dbg, act_cw(), instr_done, es[c], ec[c], (c == 3 || c == 6));
            end
            @(posedge clk);
            #1;
        end
        #1;
        vec_count++;
        if (retired !== 4'd2) begin
            err_count++;
            $display("FAIL b2b_retired: got %0d, expected 2", retired);
        end
    endtask

    task automatic test_en_drop();
        ctrl_state_t es[7] = '{IDLE, FETCH, DECODE, EXEC, ALUWB, IDLE, IDLE};
        reset_dut();
        mem_ready = 1'b1;
        opcode = OP_RTYPE;
        for (int c = 0; c < 7; c++) begin
            en = (c < 3);
            #1;
            vec_count++;
            if (state_dbg !== es[c] || instr_done !== (c == 4)) begin
                err_count++;
                $display("FAIL en_drop cyc%0d: state=%0d done=%b, expected state=%0d done=%b",
                         c, state_dbg, instr_done, es[c], (c == 4));
            end
            @(posedge clk);
            #1;
        end
        #1;
        vec_count++;
        if (retired !== 4'd1) begin
            err_count++;
            $display("FAIL en_drop_retired: got %0d, expected 1", retired);
        end
    endtask

    task automatic test_sw_rst();
        ctrl_state_t es[8] = '{IDLE, FETCH, DECODE, MEMADR, MEMWR, FETCH, DECODE, MEMADR};
        reset_dut();
        en = 1'b1;
        mem_ready = 1'b1;
        opcode = OP_SW;
        for (int c = 0; c < 8; c++) begin
            #1;
            vec_count++;
            if (state_dbg !== es[c] || instr_done !== (c == 4) ||
                (c == 4 && act_cw() !== E_MEMWR)) begin
                err_count++;
                $display("FAIL sw cyc%0d: state=%0d cw=%h done=%b, expected state=%0d done=%b",
                         c, state_dbg, act_cw(), instr_done, es[c], (c == 4));
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        #1;
        vec_count++;
        if (state_dbg !== MEMWR || act_cw() !== E_MEMWR || instr_done !== 1'b0 ||
            retired !== 4'd1) begin
            err_count++;
            $display("FAIL sw_stall: state=%0d cw=%h done=%b ret=%0d, expected MEMWR %h 0 1",
                     state_dbg, act_cw(), instr_done, retired, E_MEMWR);
        end
        rst = 1'b0;
        #1;
        vec_count++;
        if (state_dbg !== IDLE || mem_write !== 1'b0 || instr_done !== 1'b0 ||
            retired !== 4'd0) begin
            err_count++;
            $display("FAIL sw_rst: state=%0d mw=%b done=%b ret=%0d, expected IDLE 0 0 0",
                     state_dbg, mem_write, instr_done, retired);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        reset_dut();
        en = 1'b1;
        mem_ready = 1'b1;
        opcode = OP_J;
        for (int c = 0; c < 200 && n < 16; c++) begin
            #1;
            if (instr_done === 1'b1) begin
                n++;
                @(posedge clk);
                #1;
                vec_count++;
                if (retired !== 4'(n)) begin
                    err_count++;
                    $display("FAIL wrap after %0d: retired=%0d, expected %0d", n, retired, 4'(n));
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        vec_count++;
        if (n != 16) begin
            err_count++;
            $display("FAIL wrap_budget: saw %0d retirements, expected 16", n);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_en_drop();
        test_sw_rst();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
